spike_event_uart_tx: RTL and testbench

Downstream consumer of the Poisson neuron array's spike stream. Captures each {time_stamp, neuron_addr} event on its single-cycle spike pulse and buffers it in a synchronous FIFO. Serializes each event into a framed byte stream (sync byte, then event bytes MSB-first) over a valid/ready byte interface that feeds the UART transmitter. Counts events dropped on FIFO overflow so the host can detect lost spikes.

---
 rtl/spike_event_uart_tx_pkg.sv | 10 +
 rtl/spike_event_uart_tx_if.sv | 9 +
 rtl/spike_event_uart_tx_sync_fifo.sv | 44 ++++
 rtl/spike_event_uart_tx.sv | 85 ++++++++
 tb/tb_spike_event_uart_tx.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/spike_event_uart_tx_pkg.sv
// spike_event_uart_tx_pkg: shared constants, FSM state type and frame sizing helper
// Contents: SYNC_BYTE_DEF (frame header), tx_state_t (IDLE/LOAD/HDR/DATA),
//           bytes_per_event() = ceil(event_width/8)
package spike_tx_pkg;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
   typedef enum logic [1:0] {IDLE, LOAD, HDR, DATA} tx_state_t;
   function automatic int bytes_per_event(input int event_width);
      return (event_width + 7) / 8;
   endfunction
endpackage

// File: rtl/spike_event_uart_tx_if.sv
// spike_event_uart_tx_if: valid/ready byte stream towards the UART transmitter
// Signals: byte_valid (master->slave), byte_data[7:0] (master->slave), byte_ready (slave->master)
interface spike_event_uart_tx_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   modport master (output byte_valid, byte_data, input byte_ready);
   modport slave  (input byte_valid, byte_data, output byte_ready);
endinterface

// File: rtl/spike_event_uart_tx_sync_fifo.sv
// sync_fifo: synchronous FIFO with registered read data and occupancy output
// Ports: clk, reset (sync, active-high), i_push/i_data write side (ignored when full),
//        i_pop (ignored when empty) -> o_data valid the cycle after the pop,
//        o_empty, o_full, o_level (0..DEPTH)
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic                   o_empty,
   output logic                   o_full,
   output logic [$clog2(DEPTH):0] o_level
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wp, r_rp;
   logic             w_push, w_pop;
   // Pointers carry one extra MSB so full and empty differ only in that bit.
   assign o_empty = r_wp == r_rp;
   assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
   assign o_level = r_wp - r_rp;
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp   <= '0;
         r_rp   <= '0;
         o_data <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + (AW+1)'(1);
         if (w_pop) begin
            o_data <= r_mem[r_rp[AW-1:0]];
            r_rp   <= r_rp + (AW+1)'(1);
         end
      end
   end
endmodule

// File: rtl/spike_event_uart_tx.sv
// spike_event_uart_tx: buffers spike events and serializes them as [SYNC, event bytes MSB-first]
// Ports: clk, reset (sync, active-high), spike_in/event_in event capture strobe,
//        bus (master byte stream), fifo_empty/fifo_full/fifo_level occupancy,
//        overflow_count saturating dropped-event count, clear_overflow sync clear
module spike_event_uart_tx
   import spike_tx_pkg::*;
#(
   parameter int         NEURON_NUMBER = 256,
   parameter int         TS_WIDTH      = 16,
   parameter int         FIFO_DEPTH    = 16,
   parameter int         OVF_WIDTH     = 16,
   parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEF,
   localparam int        EVENT_WIDTH   = TS_WIDTH + $clog2(NEURON_NUMBER)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        spike_in,
   input  logic [EVENT_WIDTH-1:0]      event_in,
   spike_event_uart_tx_if.master       bus,
   output logic                        fifo_empty,
   output logic                        fifo_full,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [OVF_WIDTH-1:0]        overflow_count,
   input  logic                        clear_overflow
);
   localparam int BPE = bytes_per_event(EVENT_WIDTH);
   localparam int SW  = BPE * 8;
   localparam int IW  = $clog2(BPE) + 1;
   tx_state_t              r_state, w_next;
   logic [SW-1:0]          r_shift;
   logic [IW-1:0]          r_idx;
   logic [OVF_WIDTH-1:0]   r_ovf;
   logic [EVENT_WIDTH-1:0] w_rdata;
   logic                   w_pop, w_last, w_drop;
   sync_fifo #(.WIDTH(EVENT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (spike_in),
      .i_data  (event_in),
      .i_pop   (w_pop),
      .o_data  (w_rdata),
      .o_empty (fifo_empty),
      .o_full  (fifo_full),
      .o_level (fifo_level)
   );
   assign w_drop         = spike_in && fifo_full;
   assign w_last         = r_idx == IW'(BPE - 1);
   assign overflow_count = r_ovf;
   always_comb begin
      w_next         = r_state;
      w_pop          = 1'b0;
      bus.byte_valid = r_state == HDR || r_state == DATA;
      bus.byte_data  = r_state == HDR ? SYNC_BYTE : r_state == DATA ? r_shift[SW-1 -: 8] : 8'h00;
      case (r_state)
         IDLE: if (!fifo_empty) begin
            w_pop  = 1'b1;
            w_next = LOAD;
         end
         LOAD: w_next = HDR;
         HDR:  if (bus.byte_ready) w_next = DATA;
         DATA: if (bus.byte_ready && w_last) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk)
      r_state <= reset ? IDLE : w_next;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift <= '0;
         r_idx   <= '0;
         r_ovf   <= '0;
      end else begin
         if (r_state == LOAD) begin
            r_shift <= SW'(w_rdata);
            r_idx   <= '0;
         end else if (r_state == DATA && bus.byte_ready) begin
            r_shift <= r_shift << 8;
            r_idx   <= r_idx + IW'(1);
         end
         // A drop in the clearing cycle is counted after the clear.
         r_ovf <= clear_overflow ? OVF_WIDTH'(w_drop) :
                  (w_drop && !(&r_ovf)) ? r_ovf + OVF_WIDTH'(1) : r_ovf;
      end
   end
endmodule

// File: tb/tb_spike_event_uart_tx.sv
module tb_spike_event_uart_tx;
   import spike_tx_pkg::*;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        spike_in = 1'b0;
   logic        spike2 = 1'b0;
   logic        clear_overflow = 1'b0;
   logic [23:0] event_in = '0;
   logic        fifo_empty, fifo_full, e2, f2;
   logic [4:0]  fifo_level, l2;
   logic [15:0] ovf;
   logic [3:0]  ovf2;
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  exp_q[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data = '0;

   spike_event_uart_tx_if bus ();
   spike_event_uart_tx_if bus2 ();

   always #5 clk = ~clk;

   spike_event_uart_tx dut (
      .clk(clk), .reset(reset), .spike_in(spike_in), .event_in(event_in), .bus(bus),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
      .overflow_count(ovf), .clear_overflow(clear_overflow)
   );

   spike_event_uart_tx #(.OVF_WIDTH(4)) dut2 (
      .clk(clk), .reset(reset), .spike_in(spike2), .event_in(event_in), .bus(bus2),
      .fifo_empty(e2), .fifo_full(f2), .fifo_level(l2),
      .overflow_count(ovf2), .clear_overflow(1'b0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted byte is popped from the scoreboard; stalled bytes must hold.
   always @(negedge clk) begin
      if (reset) prev_stall = 1'b0;
      else begin
         if (prev_stall) begin
            chk("stall_valid", {31'b0, bus.byte_valid}, 32'd1);
            chk("stall_data", {24'b0, bus.byte_data}, {24'b0, prev_data});
         end
         if (bus.byte_valid && bus.byte_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_byte: got %0h expected no byte", bus.byte_data);
            end else chk("byte", {24'b0, bus.byte_data}, {24'b0, exp_q.pop_front()});
         end
         prev_stall = bus.byte_valid && !bus.byte_ready;
         prev_data  = bus.byte_data;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_frame(input logic [23:0] ev);
      exp_q.push_back(8'hA5);
      exp_q.push_back(ev[23:16]);
      exp_q.push_back(ev[15:8]);
      exp_q.push_back(ev[7:0]);
   endtask

   task automatic spike(input logic [23:0] ev);
      event_in = ev;
      spike_in = 1'b1;
      tick();
      spike_in = 1'b0;
   endtask

   task automatic drain(input string name, input int budget, input bit rand_ready);
      int n = 0;
      while ((exp_q.size() != 0 || !fifo_empty || bus.byte_valid) && n < budget) begin
         if (rand_ready) bus.byte_ready = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      if (n >= budget) $display("FAIL %s_timeout: %0d bytes pending, expected 0", name, exp_q.size());
      chk({name, "_drained"}, {31'b0, n < budget}, 32'd1);
      bus.byte_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1);
   end

   initial begin
      bus.byte_ready  = 1'b1;
      bus2.byte_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_empty", {31'b0, fifo_empty}, 32'd1);
      chk("rst_full", {31'b0, fifo_full}, 32'd0);
      chk("rst_level", {27'b0, fifo_level}, 32'd0);
      chk("rst_valid", {31'b0, bus.byte_valid}, 32'd0);
      chk("rst_data", {24'b0, bus.byte_data}, 32'd0);
      chk("rst_ovf", {16'b0, ovf}, 32'd0);
      // Single event and latency: spike in cycle N, header valid in N+3.
      push_frame(24'h00030A);
      spike(24'h00030A);
      tick();
      chk("lat_n2_valid", {31'b0, bus.byte_valid}, 32'd0);
      tick();
      chk("lat_n3_valid", {31'b0, bus.byte_valid}, 32'd1);
      chk("lat_n3_data", {24'b0, bus.byte_data}, 32'hA5);
      drain("single", 50, 1'b0);
      chk("single_empty", {31'b0, fifo_empty}, 32'd1);
      // Back-to-back frames.
      push_frame(24'hABCDEF);
      push_frame(24'h0100FF);
      spike(24'hABCDEF);
      spike(24'h0100FF);
      drain("b2b", 100, 1'b0);
      // Random backpressure.
      push_frame(24'h00030A);
      spike(24'h00030A);
      drain("bp", 300, 1'b1);
      // Overflow: the first event is popped into the serializer, so 17 are kept and 3 dropped.
      bus.byte_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i < 17) push_frame(24'(i));
         event_in = 24'(i);
         spike_in = 1'b1;
         tick();
      end
      spike_in = 1'b0;
      chk("ovf_full", {31'b0, fifo_full}, 32'd1);
      chk("ovf_level", {27'b0, fifo_level}, 32'd16);
      chk("ovf_count", {16'b0, ovf}, 32'd3);
      // Clear colliding with a drop, then clear alone.
      event_in = 24'hFFFFFF;
      spike_in = 1'b1;
      clear_overflow = 1'b1;
      tick();
      spike_in = 1'b0;
      chk("clr_collide", {16'b0, ovf}, 32'd1);
      chk("clr_level", {27'b0, fifo_level}, 32'd16);
      tick();
      clear_overflow = 1'b0;
      chk("clr_alone", {16'b0, ovf}, 32'd0);
      bus.byte_ready = 1'b1;
      drain("ovf_drain", 400, 1'b0);
      // Saturation on the 4-bit counter: 17 accepted, then drops counted up to 15.
      event_in = 24'h000001;
      spike2 = 1'b1;
      repeat (31) tick();
      chk("sat_14", {28'b0, ovf2}, 32'd14);
      repeat (9) tick();
      spike2 = 1'b0;
      chk("sat_15", {28'b0, ovf2}, 32'd15);
      chk("sat_full", {31'b0, f2}, 32'd1);
      // Reset after header and first data byte.
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h12);
      spike(24'h123456);
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_valid", {31'b0, bus.byte_valid}, 32'd0);
      chk("mid_rst_level", {27'b0, fifo_level}, 32'd0);
      chk("mid_rst_bytes", exp_q.size(), 32'd0);
      exp_q.delete();
      push_frame(24'h0ABCDE);
      spike(24'h0ABCDE);
      drain("post_rst", 50, 1'b0);
      repeat (3) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
